// File: rtl/vj_lii_pkg.sv
// Shared LII link constants, ID type and receive FSM state encoding.
package vj_lii_pkg;

    localparam int unsigned LII_PW      = 256;
    localparam int unsigned VJ_RESULT_W = 160;
    localparam int unsigned VJ_WORD_W   = 32;

    typedef logic [7:0] lii_id_t;

    typedef enum logic {
        RX_IDLE,
        RX_SEND
    } vj_rx_state_e;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_cnt16 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'h0;
        end else if (i_en && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'h1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vj_result_rx.sv
// LII result receiver: filters beats by destination ID and serializes each result as NW words.
// Statistics counters are built only when VJ_RESULT_RX_STATS_EN is defined.
module vj_result_rx
    import vj_lii_pkg::*;
#(
    parameter int unsigned PW    = LII_PW,
    parameter int unsigned RW    = VJ_RESULT_W,
    parameter int unsigned OW    = VJ_WORD_W,
    parameter lii_id_t     MY_ID = 8'h01
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  lii_id_t       lii_in_p0_src,
    input  lii_id_t       lii_in_p0_dst,
    output logic [OW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output lii_id_t       m_tuser,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   result_cnt
);

    localparam int unsigned NW = RW / OW;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    vj_rx_state_e  r_state;
    logic [IW-1:0] r_idx;
    logic [RW-1:0] r_hold;
    lii_id_t       r_src;
    logic          r_valid;
    logic          r_last;
    logic          r_rdy;

    logic          w_in_rdy;
    logic          w_in_fire;
    logic          w_match;
    logic          w_load;
    logic          w_drop;
    logic          w_out_fire;
    logic          w_done;
    logic [IW-1:0] w_idx_nxt;
    logic          w_unused_hi;

    // In SEND a new beat is only taken on the last-word handshake, giving bubble-free reload.
    assign w_in_rdy   = (r_state == RX_IDLE) ? r_rdy : (m_tready & r_last);
    assign w_in_fire  = lii_in_p0_tvalid & w_in_rdy;
    assign w_match    = (lii_in_p0_dst == MY_ID);
    assign w_load     = w_in_fire & w_match;
    assign w_drop     = w_in_fire & ~w_match;
    assign w_out_fire = r_valid & m_tready;
    assign w_done     = w_out_fire & r_last;
    assign w_idx_nxt  = r_idx + IW'(1);

    assign w_unused_hi = ^lii_in_p0_tdata[PW-1:RW];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= RX_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_load) begin
                r_state <= RX_SEND;
                r_hold  <= lii_in_p0_tdata[RW-1:0];
                r_src   <= lii_in_p0_src;
                r_idx   <= '0;
                r_valid <= 1'b1;
                r_last  <= (NW == 1);
            end else if (w_done) begin
                r_state <= RX_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_out_fire) begin
                // Shifting keeps the current word in the low bits, so m_tdata is a plain flop.
                r_hold <= r_hold >> OW;
                r_idx  <= w_idx_nxt;
                r_last <= (w_idx_nxt == IW'(NW - 1));
            end
        end
    end

    assign lii_in_p0_tready = w_in_rdy;
    assign m_tdata          = r_hold[OW-1:0];
    assign m_tvalid         = r_valid;
    assign m_tlast          = r_last;
    assign m_tuser          = r_src;

`ifdef VJ_RESULT_RX_STATS_EN
    sat_cnt16 u_drop_cnt (
        .i_clk   (aclk),
        .i_rst_n (arstn),
        .i_en    (w_drop),
        .o_cnt   (drop_cnt)
    );

    sat_cnt16 u_result_cnt (
        .i_clk   (aclk),
        .i_rst_n (arstn),
        .i_en    (w_done),
        .o_cnt   (result_cnt)
    );
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop;
    assign drop_cnt       = 16'h0;
    assign result_cnt     = 16'h0;
`endif

endmodule
